// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga pipeline: decoded instructions, reorder-buffer
// entries and writeback completions.
package tartaruga_pkg;

  localparam int unsigned ROB_SIZE     = 16;
  localparam int unsigned ROB_IDX_BITS = $clog2(ROB_SIZE);

  typedef logic [31:0]             bus32_t;
  typedef logic [ROB_IDX_BITS-1:0] rob_idx_t;
  typedef logic [ROB_IDX_BITS:0]   rob_cnt_t;
  typedef logic [4:0]              reg_addr_t;

  localparam rob_cnt_t ROB_FULL_CNT = rob_cnt_t'(ROB_SIZE);
  localparam bus32_t   ADDR_XCPT    = 32'h0000_2000;

  typedef enum logic [3:0] {
    XCPT_NONE            = 4'd0,
    XCPT_FETCH_MISALIGN  = 4'd1,
    XCPT_ILLEGAL_INSTR   = 4'd2,
    XCPT_BREAKPOINT      = 4'd3,
    XCPT_LOAD_MISALIGN   = 4'd4,
    XCPT_STORE_MISALIGN  = 4'd6,
    XCPT_ECALL           = 4'd11
  } xcpt_code_t;

  typedef struct packed {
    bus32_t     pc;
    bus32_t     instr;
    reg_addr_t  addr_rd;
    logic       write_enable;
    logic       store_to_mem;
    bus32_t     kanata_id;
    logic       xcpt;
    xcpt_code_t xcpt_code;
  } instr_data_t;

  typedef struct packed {
    logic       valid;
    logic       completed;
    bus32_t     pc;
    bus32_t     instr;
    reg_addr_t  addr_rd;
    logic       write_enable;
    logic       store_to_mem;
    bus32_t     kanata_id;
    bus32_t     result;
    bus32_t     new_pc;
    logic       branch_taken;
    logic       xcpt;
    xcpt_code_t xcpt_code;
  } rob_entry_t;

  typedef struct packed {
    rob_idx_t   idx;
    bus32_t     result;
    bus32_t     new_pc;
    logic       branch_taken;
    logic       xcpt;
    xcpt_code_t xcpt_code;
  } rob_cmpl_t;

  // Pointers wrap naturally because ROB_SIZE is a power of two.
  function automatic rob_idx_t rob_ptr_inc(input rob_idx_t ptr);
    return ptr + rob_idx_t'(1);
  endfunction

endpackage

// File: rtl/rob_controller_storage.sv
// Reorder-buffer entry array: allocate, completion and commit-clear write ports,
// global clear, and a combinational read of the head entry.
module rob_storage
  import tartaruga_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clear_i,
  input  logic        alloc_we_i,
  input  rob_idx_t    alloc_idx_i,
  input  instr_data_t alloc_instr_i,
  input  logic        cmpl_we_i,
  input  rob_cmpl_t   cmpl_i,
  input  logic        commit_clr_i,
  input  rob_idx_t    head_idx_i,
  output rob_entry_t  head_entry_o
);

  rob_entry_t entry_q [ROB_SIZE];
  rob_entry_t entry_d [ROB_SIZE];

  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      entry_d[i] = entry_q[i];

      if (cmpl_we_i && (cmpl_i.idx == rob_idx_t'(i)) && entry_q[i].valid) begin
        entry_d[i].completed    = 1'b1;
        entry_d[i].result       = cmpl_i.result;
        entry_d[i].new_pc       = cmpl_i.new_pc;
        entry_d[i].branch_taken = cmpl_i.branch_taken;
        entry_d[i].xcpt         = entry_q[i].xcpt | cmpl_i.xcpt;
        if (cmpl_i.xcpt) begin
          entry_d[i].xcpt_code = cmpl_i.xcpt_code;
        end
      end

      // A fetch/decode fault has nothing left to execute, so it is born completed.
      if (alloc_we_i && (alloc_idx_i == rob_idx_t'(i))) begin
        entry_d[i].valid        = 1'b1;
        entry_d[i].completed    = alloc_instr_i.xcpt;
        entry_d[i].pc           = alloc_instr_i.pc;
        entry_d[i].instr        = alloc_instr_i.instr;
        entry_d[i].addr_rd      = alloc_instr_i.addr_rd;
        entry_d[i].write_enable = alloc_instr_i.write_enable;
        entry_d[i].store_to_mem = alloc_instr_i.store_to_mem;
        entry_d[i].kanata_id    = alloc_instr_i.kanata_id;
        entry_d[i].result       = '0;
        entry_d[i].new_pc       = '0;
        entry_d[i].branch_taken = 1'b0;
        entry_d[i].xcpt         = alloc_instr_i.xcpt;
        entry_d[i].xcpt_code    = alloc_instr_i.xcpt_code;
      end

      if (commit_clr_i && (head_idx_i == rob_idx_t'(i))) begin
        entry_d[i].valid     = 1'b0;
        entry_d[i].completed = 1'b0;
      end

      if (clear_i) begin
        entry_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign head_entry_o = entry_q[head_idx_i];

endmodule

// File: rtl/rob_controller.sv
// Reorder-buffer sequencer: head/tail pointers, occupancy, allocate/commit
// handshakes and the commit-time flush for exceptions and taken branches.
module rob_controller
  import tartaruga_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  alloc_valid_i,
  input  instr_data_t           alloc_instr_i,
  output logic                  alloc_ready_o,
  output logic [ROB_IDX_BITS-1:0] alloc_idx_o,
  input  logic                  cmpl_valid_i,
  input  rob_cmpl_t             cmpl_i,
  output logic                  commit_valid_o,
  input  logic                  commit_ready_i,
  output rob_entry_t            commit_entry_o,
  output logic                  flush_o,
  output logic [31:0]           flush_pc_o,
  output logic [ROB_IDX_BITS:0] count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  rob_idx_t   head_q, head_d;
  rob_idx_t   tail_q, tail_d;
  rob_cnt_t   count_q, count_d;
  rob_entry_t head_entry;
  logic       commit_fire;
  logic       alloc_fire;
  logic       flush;

  rob_storage u_storage (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .clear_i       (flush),
    .alloc_we_i    (alloc_fire),
    .alloc_idx_i   (tail_q),
    .alloc_instr_i (alloc_instr_i),
    .cmpl_we_i     (cmpl_valid_i && !flush),
    .cmpl_i        (cmpl_i),
    .commit_clr_i  (commit_fire),
    .head_idx_i    (head_q),
    .head_entry_o  (head_entry)
  );

  assign commit_valid_o = head_entry.valid && head_entry.completed;
  assign commit_fire    = commit_valid_o && commit_ready_i;
  assign flush          = commit_fire && (head_entry.xcpt || head_entry.branch_taken);
  assign full_o         = (count_q == ROB_FULL_CNT);
  assign empty_o        = (count_q == '0);
  // Ready looks only at the registered count, never at a same-cycle commit.
  assign alloc_ready_o  = !full_o && !flush;
  assign alloc_fire     = alloc_valid_i && alloc_ready_o;

  assign alloc_idx_o    = tail_q;
  assign count_o        = count_q;
  assign commit_entry_o = head_entry;
  assign flush_o        = flush;
  assign flush_pc_o     = !flush           ? 32'h0 :
                          head_entry.xcpt  ? ADDR_XCPT : head_entry.new_pc;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_fire) begin
        tail_d = rob_ptr_inc(tail_q);
      end
      if (commit_fire) begin
        head_d = rob_ptr_inc(head_q);
      end
      unique case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + rob_cnt_t'(1);
        2'b01:   count_d = count_q - rob_cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob_controller.sv
// Directed bench for rob_controller; expected retirements are queued by the
// stimulus and checked by an independent commit monitor.
module tb_rob_controller;
  import tartaruga_pkg::*;

  logic        clk;
  logic        rstn_i;
  logic        alloc_valid_i;
  instr_data_t alloc_instr_i;
  logic        alloc_ready_o;
  logic [ROB_IDX_BITS-1:0] alloc_idx_o;
  logic        cmpl_valid_i;
  rob_cmpl_t   cmpl_i;
  logic        commit_valid_o;
  logic        commit_ready_i;
  rob_entry_t  commit_entry_o;
  logic        flush_o;
  logic [31:0] flush_pc_o;
  logic [ROB_IDX_BITS:0] count_o;
  logic        empty_o;
  logic        full_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic        flush;
    logic [31:0] flush_pc;
  } exp_commit_t;

  exp_commit_t exp_q[$];

  rob_controller dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_instr_i  (alloc_instr_i),
    .alloc_ready_o  (alloc_ready_o),
    .alloc_idx_o    (alloc_idx_o),
    .cmpl_valid_i   (cmpl_valid_i),
    .cmpl_i         (cmpl_i),
    .commit_valid_o (commit_valid_o),
    .commit_ready_i (commit_ready_i),
    .commit_entry_o (commit_entry_o),
    .flush_o        (flush_o),
    .flush_pc_o     (flush_pc_o),
    .count_o        (count_o),
    .empty_o        (empty_o),
    .full_o         (full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic xcpt, input xcpt_code_t code);
    alloc_valid_i           = 1'b1;
    alloc_instr_i           = '0;
    alloc_instr_i.pc        = pc;
    alloc_instr_i.instr     = 32'h0000_0013 | (pc << 8);
    alloc_instr_i.addr_rd   = pc[6:2];
    alloc_instr_i.write_enable = 1'b1;
    alloc_instr_i.kanata_id = pc >> 2;
    alloc_instr_i.xcpt      = xcpt;
    alloc_instr_i.xcpt_code = code;
  endtask

  task automatic set_cmpl(input rob_idx_t idx, input logic [31:0] result,
                          input logic taken, input logic [31:0] new_pc);
    cmpl_valid_i        = 1'b1;
    cmpl_i              = '0;
    cmpl_i.idx          = idx;
    cmpl_i.result       = result;
    cmpl_i.branch_taken = taken;
    cmpl_i.new_pc       = new_pc;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] result,
                          input logic fl, input logic [31:0] fpc);
    exp_commit_t e;
    e.pc = pc; e.result = result; e.flush = fl; e.flush_pc = fpc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
  endtask

  // Commit monitor: every accepted retirement must match the head of the queue.
  always @(negedge clk) begin
    if (rstn_i && commit_valid_o && commit_ready_i) begin
      $display("commit pc=0x%08h result=0x%08h flush=%0b flush_pc=0x%08h",
               commit_entry_o.pc, commit_entry_o.result, flush_o, flush_pc_o);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_commit: got pc 0x%08h, expected no commit", commit_entry_o.pc);
      end else begin
        exp_commit_t e;
        e = exp_q.pop_front();
        chk("commit_pc", commit_entry_o.pc, e.pc);
        chk("commit_result", commit_entry_o.result, e.result);
        chk("commit_flush", 32'(flush_o), 32'(e.flush));
        chk("commit_flush_pc", flush_pc_o, e.flush_pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected $finish before 100000");
    $fatal(1);
  end

  initial begin
    rstn_i         = 1'b0;
    alloc_valid_i  = 1'b0;
    alloc_instr_i  = '0;
    cmpl_valid_i   = 1'b0;
    cmpl_i         = '0;
    commit_ready_i = 1'b1;
    tick();
    tick();
    rstn_i = 1'b1;
    #1;
    chk("rst_alloc_ready", 32'(alloc_ready_o), 32'd1);
    chk("rst_commit_valid", 32'(commit_valid_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);

    // In-order retirement despite reverse-order completion.
    for (int i = 0; i < 3; i++) begin
      set_alloc(32'(i * 4), 1'b0, XCPT_NONE);
      #1;
      chk("t1_alloc_idx", 32'(alloc_idx_o), 32'(i));
      tick();
    end
    alloc_valid_i = 1'b0;
    #1;
    chk("t1_count3", 32'(count_o), 32'd3);
    push_exp(32'h0, 32'hA0, 1'b0, 32'h0);
    push_exp(32'h4, 32'hA1, 1'b0, 32'h0);
    push_exp(32'h8, 32'hA2, 1'b0, 32'h0);
    for (int i = 2; i >= 0; i--) begin
      set_cmpl(rob_idx_t'(i), 32'hA0 + 32'(i), 1'b0, 32'h0);
      #1;
      chk("t1_no_early_commit", 32'(commit_valid_o), 32'd0);
      tick();
    end
    cmpl_valid_i = 1'b0;
    #1;
    chk("t1_commit_start", 32'(commit_valid_o), 32'd1);
    tick(); tick(); tick();
    chk("t1_count0", 32'(count_o), 32'd0);
    chk("t1_empty", 32'(empty_o), 32'd1);

    // Fill to 16, hold the 17th request, free one slot.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_alloc(32'h1000 + 32'(i * 4), 1'b0, XCPT_NONE);
      tick();
    end
    set_alloc(32'h1040, 1'b0, XCPT_NONE);
    set_cmpl(rob_idx_t'(0), 32'hB0, 1'b0, 32'h0);
    push_exp(32'h1000, 32'hB0, 1'b0, 32'h0);
    #1;
    chk("t2_full", 32'(full_o), 32'd1);
    chk("t2_ready_full", 32'(alloc_ready_o), 32'd0);
    chk("t2_count16", 32'(count_o), 32'd16);
    chk("t2_tail_wrap", 32'(alloc_idx_o), 32'd0);
    tick();
    cmpl_valid_i = 1'b0;
    #1;
    chk("t2_commit_valid", 32'(commit_valid_o), 32'd1);
    chk("t2_ready_while_commit", 32'(alloc_ready_o), 32'd0);
    tick();
    chk("t2_ready_after", 32'(alloc_ready_o), 32'd1);
    chk("t2_count15", 32'(count_o), 32'd15);
    chk("t2_tail_still0", 32'(alloc_idx_o), 32'd0);
    tick();
    alloc_valid_i = 1'b0;
    #1;
    chk("t2_count16_again", 32'(count_o), 32'd16);
    chk("t2_tail1", 32'(alloc_idx_o), 32'd1);

    // Slow MUL at the head holds back a finished ALU op.
    do_reset();
    set_alloc(32'h200, 1'b0, XCPT_NONE);
    tick();
    set_alloc(32'h204, 1'b0, XCPT_NONE);
    tick();
    alloc_valid_i = 1'b0;
    set_cmpl(rob_idx_t'(1), 32'hC1, 1'b0, 32'h0);
    push_exp(32'h200, 32'hC0, 1'b0, 32'h0);
    push_exp(32'h204, 32'hC1, 1'b0, 32'h0);
    tick();
    set_cmpl(rob_idx_t'(5), 32'hDEAD, 1'b1, 32'h999);
    #1;
    chk("t3_alu_held", 32'(commit_valid_o), 32'd0);
    tick();
    cmpl_valid_i = 1'b0;
    tick();
    tick();
    set_cmpl(rob_idx_t'(0), 32'hC0, 1'b0, 32'h0);
    tick();
    cmpl_valid_i = 1'b0;
    #1;
    chk("t3_mul_commit", 32'(commit_valid_o), 32'd1);
    tick();
    chk("t3_alu_commit", 32'(commit_valid_o), 32'd1);
    tick();
    chk("t3_empty", 32'(empty_o), 32'd1);
    chk("t3_count_ghost", 32'(count_o), 32'd0);

    // Taken branch at the head flushes and drops the same-cycle allocation.
    do_reset();
    set_alloc(32'h300, 1'b0, XCPT_NONE);
    tick();
    alloc_valid_i = 1'b0;
    set_cmpl(rob_idx_t'(0), 32'h0, 1'b1, 32'h100);
    tick();
    cmpl_valid_i = 1'b0;
    set_alloc(32'h304, 1'b0, XCPT_NONE);
    push_exp(32'h300, 32'h0, 1'b1, 32'h100);
    #1;
    chk("t4_commit_valid", 32'(commit_valid_o), 32'd1);
    chk("t4_flush", 32'(flush_o), 32'd1);
    chk("t4_flush_pc", flush_pc_o, 32'h100);
    chk("t4_ready_flush", 32'(alloc_ready_o), 32'd0);
    tick();
    alloc_valid_i = 1'b0;
    #1;
    chk("t4_count0", 32'(count_o), 32'd0);
    chk("t4_empty", 32'(empty_o), 32'd1);
    chk("t4_no_commit", 32'(commit_valid_o), 32'd0);

    // Decode fault at the head; the completed younger entry is squashed.
    do_reset();
    commit_ready_i = 1'b0;
    set_alloc(32'h400, 1'b1, XCPT_ILLEGAL_INSTR);
    tick();
    set_alloc(32'h404, 1'b0, XCPT_NONE);
    #1;
    chk("t5_born_completed", 32'(commit_valid_o), 32'd1);
    tick();
    alloc_valid_i = 1'b0;
    set_cmpl(rob_idx_t'(1), 32'hE1, 1'b0, 32'h0);
    tick();
    cmpl_valid_i = 1'b0;
    push_exp(32'h400, 32'h0, 1'b1, ADDR_XCPT);
    commit_ready_i = 1'b1;
    #1;
    chk("t5_flush", 32'(flush_o), 32'd1);
    chk("t5_flush_pc", flush_pc_o, 32'h2000);
    chk("t5_xcpt_code", 32'(commit_entry_o.xcpt_code), 32'(XCPT_ILLEGAL_INSTR));
    tick();
    chk("t5_count0", 32'(count_o), 32'd0);
    chk("t5_younger_gone", 32'(commit_valid_o), 32'd0);
    tick();
    tick();

    // Consumer stall, then reset in the middle of it.
    set_alloc(32'h500, 1'b0, XCPT_NONE);
    tick();
    alloc_valid_i  = 1'b0;
    commit_ready_i = 1'b0;
    set_cmpl(rob_idx_t'(0), 32'hF0, 1'b0, 32'h0);
    tick();
    cmpl_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_stall_valid", 32'(commit_valid_o), 32'd1);
      chk("t6_stall_pc", commit_entry_o.pc, 32'h500);
      chk("t6_stall_result", commit_entry_o.result, 32'hF0);
      chk("t6_stall_count", 32'(count_o), 32'd1);
      tick();
    end
    do_reset();
    #1;
    chk("t6_rst_empty", 32'(empty_o), 32'd1);
    chk("t6_rst_commit", 32'(commit_valid_o), 32'd0);
    chk("t6_rst_count", 32'(count_o), 32'd0);
    commit_ready_i = 1'b1;
    tick(); tick(); tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_controller.md
Name: rob_controller

Overview:
- Sequences the 16-entry reorder buffer of the in-order-issue, variable-latency-execute pipeline (1-cycle ALU, 5-cycle MUL).
- Allocates entries at decode and records out-of-order completions from writeback.
- Retires entries strictly in program order and raises a pipeline flush when a retiring entry carries an exception or a taken branch/jump.
- Sits between decode (allocation), writeback (completion) and the register file/store drain (commit).

Parameters:
- ROB_SIZE, 16, number of entries; must be a power of two.
- ROB_IDX_BITS, $clog2(ROB_SIZE), width of entry index and of the head/tail pointers.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; one clock, synchronous and active-low.
- alloc_valid_i  in  1  decode requests an entry.
- alloc_instr_i  in  instr_data_t  decoded instruction.
- alloc_ready_o  out  1  entry available this cycle.
- alloc_idx_o  out  ROB_IDX_BITS  index granted (current tail).
- cmpl_valid_i  in  1  writeback completion strobe.
- cmpl_i  in  rob_cmpl_t  completion: idx, result, new_pc, branch_taken, xcpt, xcpt_code.
- commit_valid_o  out  1  head entry retiring.
- commit_ready_i  in  1  consumer accepts the retirement (store drain may stall).
- commit_entry_o  out  rob_entry_t  head entry contents.
- flush_o  out  1  pipeline flush, asserted in the commit cycle.
- flush_pc_o  out  32  redirect target.
- count_o  out  ROB_IDX_BITS+1  occupancy, 0..16.
- empty_o  out  1  count == 0.
- full_o  out  1  count == ROB_SIZE.

Behaviour:
- Reset (rstn_i low at an edge):
  - All entry valid/completed bits cleared; head = tail = 0; count = 0.
  - Outputs settle to: alloc_ready_o=1, commit_valid_o=0, flush_o=0, empty_o=1, full_o=0.
  - Reset mid-operation discards all entries; no commit or flush is produced.
- Allocation:
  - alloc_ready_o = !full_o && !flush_o; it does not depend on a same-cycle commit.
  - On alloc_valid_i && alloc_ready_o: entry[tail] is written with valid=1 and with pc, instr, addr_rd, write_enable, store_to_mem, kanata_id, xcpt and xcpt_code taken from alloc_instr_i; result=0, new_pc=0, branch_taken=0; tail advances with wrap 15→0.
  - completed=1 at allocation if alloc_instr_i.xcpt (fetch/decode fault); otherwise completed=0.
  - alloc_idx_o always shows tail.
- Completion:
  - On cmpl_valid_i, if entry[cmpl_i.idx] is valid: set completed and write result, new_pc and branch_taken.
  - cmpl_i.xcpt ORs into the entry's xcpt; xcpt_code is overwritten only when cmpl_i.xcpt=1.
  - Completion to an invalid index is ignored.
  - Completion to the head is visible at commit the next cycle; there is no same-cycle bypass.
- Commit:
  - commit_valid_o = entry[head].valid && entry[head].completed; commit_entry_o = entry[head].
  - On commit_valid_o && commit_ready_i: clear entry[head].valid; head advances with wrap.
  - An entry with xcpt=1 still commits; the consumer must suppress the rd write and the store.
- Flush:
  - flush_o = commit handshake && (head.xcpt || head.branch_taken).
  - flush_pc_o = ADDR_XCPT if head.xcpt, else head.new_pc; exception takes priority over branch. flush_pc_o = 0 when flush_o = 0.
  - On the flush edge all entries are cleared; head = tail = 0; count = 0.
  - Allocation and completion in the flush cycle are dropped.
- Occupancy:
  - count +1 on allocate only, −1 on commit only, unchanged on both or neither; forced to 0 on flush.
  - When full and committing, alloc_ready_o stays 0 that cycle; allocation resumes the next cycle.
- Latency:
  - Allocate-to-earliest-commit = 1 cycle, only for an entry allocated already completed.
  - Completion-to-commit = 1 cycle.
  - Sustained throughput: 1 allocation and 1 commit per cycle.

Decomposition:
- Add to tartaruga_pkg:
  - rob_cmpl_t, packed: rob_idx_t idx; bus32_t result; bus32_t new_pc; logic branch_taken; logic xcpt; xcpt_code_t xcpt_code.
  - ROB_SIZE, rob_idx_t, rob_entry_t and ADDR_XCPT already live there and are reused.
- One sub-module, rob_storage: the entry array with allocate write port, completion write port, commit clear port, global clear, and combinational head read.
- rob_controller keeps the pointers, count, handshakes and flush logic.

Test Plan:
- Reset, then allocate 3 ALU ops (pc 0x0/0x4/0x8); complete idx 2, 1, 0 on consecutive cycles → commits pc 0x0, 0x4, 0x8 in order, all starting the cycle after idx 0 completes; count_o 3→0.
- Allocate 16 entries → full_o=1, alloc_ready_o=0 and the 17th request is held; complete and commit the head → alloc_ready_o=1 the cycle after; tail wraps to 0.
- MUL at idx 0 completes 4 cycles after ALU at idx 1 → idx 1 is held until idx 0 commits, then both commit on consecutive cycles.
- Head completes with branch_taken=1, new_pc=0x100, while alloc_valid_i=1 → commit_valid_o=1, flush_o=1, flush_pc_o=0x100; allocation dropped; next cycle count_o=0, empty_o=1.
- Entry allocated with alloc_instr_i.xcpt=1 and XCPT_ILLEGAL_INSTR behind a younger completed entry → at head: flush_pc_o=0x2000; the younger entry is discarded and never committed.
- commit_ready_i=0 for 3 cycles with a completed head → commit_valid_o held high, commit_entry_o stable, count_o unchanged; rstn_i pulsed low mid-stall → empty_o=1 and no commit issued.
